// File: rtl/r2r_dac_sequencer.sv
// R2R DAC sequencer: a programmable divider paces hold, ramp, triangle or
// FIFO-fed stream codes onto a 4-bit R2R ladder.
module r2r_dac_sequencer #(
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  input  logic             ext_valid,
  input  logic [3:0]       ext_data,
  output logic             ext_ready,
  output logic [3:0]       r2r_out,
  output logic             sample_tick,
  output logic             underrun,
  output logic             running
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {
    M_HOLD, M_RAMP, M_TRI, M_STREAM
  } mode_t;

  state_t           state, state_n;
  mode_t            mode;
  logic [DIV_W-1:0] div, cnt;
  logic [3:0]       step, holdval;
  logic             dir, dir_n;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  logic             wr_ctrl, wr_div, wr_clr, cnt_clr;
  logic             tick, stream, push, pop, urun;
  logic [4:0]       sum;
  logic [3:0]       tri_up, tri_dn, code_n;

  always_comb begin
    wr_ctrl   = cfg_we && (cfg_addr == 3'd0);
    wr_div    = cfg_we && (cfg_addr == 3'd1);
    wr_clr    = cfg_we && (cfg_addr == 3'd4);
    cnt_clr   = wr_ctrl || wr_div;
    tick      = (state == RUN) && !cnt_clr && (cnt == div);
    stream    = (mode == M_STREAM);
    ext_ready = (state == RUN) && stream && (count < FULL);
    push      = ext_valid && ext_ready;
    pop       = tick && stream && (count != '0);
    urun      = tick && stream && (count == '0);

    state_n = state;
    if (wr_ctrl)
      state_n = cfg_data[0] ? RUN : IDLE;

    sum    = {1'b0, r2r_out} + {1'b0, step};
    tri_up = (sum >= 5'd15) ? 4'd15 : sum[3:0];
    tri_dn = (r2r_out <= step) ? 4'd0 : r2r_out - step;

    code_n = r2r_out;
    dir_n  = dir;
    case (mode)
      M_HOLD: code_n = holdval;
      M_RAMP: code_n = sum[3:0];
      M_TRI: begin
        if (dir) begin
          code_n = tri_up;
          if (tri_up == 4'd15) dir_n = 1'b0;
        end else begin
          code_n = tri_dn;
          if (tri_dn == 4'd0) dir_n = 1'b1;
        end
      end
      M_STREAM: if (pop) code_n = mem[rd_ptr];
      default: code_n = r2r_out;
    endcase
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= ext_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode        <= M_HOLD;
      div         <= '0;
      step        <= 4'd1;
      holdval     <= 4'd0;
      cnt         <= '0;
      dir         <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      r2r_out     <= 4'd0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      running     <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          3'd0: mode    <= mode_t'(cfg_data[2:1]);
          3'd1: div     <= DIV_W'(cfg_data);
          3'd2: step    <= cfg_data[3:0];
          3'd3: holdval <= cfg_data[3:0];
          default: ;
        endcase
      end

      state       <= state_n;
      running     <= (state_n == RUN);
      sample_tick <= tick;

      if (cnt_clr || tick || state != RUN)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (urun)
        underrun <= 1'b1;
      else if (wr_clr)
        underrun <= 1'b0;

      // Leaving RUN shows HOLDVAL on the very next cycle.
      if (state_n == IDLE)
        r2r_out <= holdval;
      else if (tick)
        r2r_out <= code_n;

      if (state != RUN || wr_ctrl)
        dir <= 1'b1;
      else if (tick && mode == M_TRI)
        dir <= dir_n;

      if (state != RUN) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Directed bench for r2r_dac_sequencer: divider, ramp, triangle,
// stream FIFO, disable and reset behaviour.
module tb_r2r_dac_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       ext_valid;
  logic [3:0] ext_data;
  logic       ext_ready;
  logic [3:0] r2r_out;
  logic       sample_tick;
  logic       underrun;
  logic       running;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  r2r_dac_sequencer #(.DIV_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(ext_ready),
    .r2r_out(r2r_out), .sample_tick(sample_tick),
    .underrun(underrun), .running(running)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_tick && n < 20);
    chk("tick_seen", sample_tick, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] tri_seq [7] = '{4'd6, 4'd12, 4'd15, 4'd9, 4'd3, 4'd0, 4'd6};
  logic [3:0] str_seq [3] = '{4'h5, 4'hA, 4'h3};
  logic [3:0] pop_seq [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hD, 4'hE};
  logic [3:0] psh_seq [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    int n;
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h03;
    ext_valid = 1'b1; ext_data = 4'h7;
    step(); step();
    chk("rst_r2r", r2r_out, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_urun", underrun, 0);
    chk("rst_run", running, 0);
    chk("rst_rdy", ext_ready, 0);
    rst = 1'b0; cfg_we = 1'b0; ext_valid = 1'b0;
    step();
    chk("post_rst_run", running, 0);

    // RAMP, DIV=3, STEP=1
    cfg(3'd1, 8'd3);
    cfg(3'd2, 8'd1);
    cfg(3'd0, 8'h03);
    chk("ramp_run", running, 1);
    chk("ramp_start", r2r_out, 0);
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      chk("ramp_period", n, 4);
      chk("ramp_code", r2r_out, k % 16);
    end

    // disable mid-RAMP
    cfg(3'd3, 8'd9);
    cfg(3'd0, 8'h00);
    chk("dis_run", running, 0);
    chk("dis_r2r", r2r_out, 9);
    step();
    chk("idle_tick", sample_tick, 0);
    chk("idle_rdy", ext_ready, 0);
    chk("idle_r2r", r2r_out, 9);

    // TRIANGLE, STEP=6, DIV=0
    cfg(3'd3, 8'd0);
    cfg(3'd2, 8'd6);
    cfg(3'd1, 8'd0);
    cfg(3'd0, 8'h05);
    chk("tri_start", r2r_out, 0);
    chk("tri_notick", sample_tick, 0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("tri_tick", sample_tick, 1);
      chk("tri_code", r2r_out, tri_seq[k]);
      chk("tri_run", running, 1);
    end

    // STREAM: preload at slow rate, then drain at DIV=0
    cfg(3'd0, 8'h00);
    cfg(3'd1, 8'd255);
    cfg(3'd0, 8'h07);
    chk("str_rdy", ext_ready, 1);
    ext_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ext_data = str_seq[k];
      step();
    end
    ext_valid = 1'b0;
    chk("str_rdy3", ext_ready, 1);
    chk("str_hold", r2r_out, 0);
    cfg(3'd1, 8'd0);
    chk("str_noclr_tick", sample_tick, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("str_code", r2r_out, str_seq[k]);
      chk("str_urun0", underrun, 0);
    end
    step();
    chk("urun_set", underrun, 1);
    chk("urun_hold", r2r_out, 3);
    chk("urun_tick", sample_tick, 1);
    cfg(3'd4, 8'd0);
    chk("urun_setwins", underrun, 1);
    cfg(3'd1, 8'd255);
    cfg(3'd4, 8'd0);
    chk("urun_clr", underrun, 0);

    // FIFO full, then push/pop at constant occupancy
    ext_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ext_data = psh_seq[k];
      step();
      if (k == 2) chk("full_rdy3", ext_ready, 1);
    end
    chk("full_rdy", ext_ready, 0);
    ext_data = 4'hF;
    step();
    chk("full_rdy_hold", ext_ready, 0);
    chk("full_r2r", r2r_out, 3);
    cfg(3'd1, 8'd0);
    chk("full_rdy_clr", ext_ready, 0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("pp_code", r2r_out, pop_seq[k]);
      chk("pp_rdy", ext_ready, 1);
      if (k == 0) ext_data = 4'hC;
      if (k == 1) ext_data = 4'hD;
      if (k == 2) ext_data = 4'hE;
      if (k == 3) ext_valid = 1'b0;
    end
    chk("pp_urun", underrun, 0);

    // reset during STREAM beats cfg and push
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h07;
    ext_valid = 1'b1;
    step();
    chk("mrst_r2r", r2r_out, 0);
    chk("mrst_tick", sample_tick, 0);
    chk("mrst_urun", underrun, 0);
    chk("mrst_run", running, 0);
    chk("mrst_rdy", ext_ready, 0);
    rst = 1'b0; cfg_we = 1'b0; ext_valid = 1'b0;
    step();
    chk("mrst_idle", running, 0);
    chk("mrst_hold", r2r_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
